ascii_msg_sequencer: RTL and testbench

Parametrised successor to the single-output message display. The block streams one of four built-in ASCII messages, one character per programmable step period, onto an 8-bit character bus for the 7-segment or UART stage. It adds:

- a prescaler,
- loop, one-shot, ping-pong and reverse modes,
- hold,
- a per-character valid strobe,
- pass-boundary latching of message and mode selects.

---
 rtl/ascii_msg_sequencer_if.sv | 28 ++
 rtl/ascii_msg_sequencer.sv | 176 +++++++++++++++++
 tb/tb_ascii_msg_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_msg_sequencer_if.sv
// Character-bus interface for ascii_msg_sequencer: control inputs from the
// host side and the registered character stream back to it.
interface ascii_msg_sequencer_if #(
    parameter int DIV_W = 16,
    parameter int IDX_W = 4
);
    logic             ena;
    logic             start;
    logic             hold;
    logic [1:0]       msg_sel;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [7:0]       char_out;
    logic             char_valid;
    logic [IDX_W-1:0] char_idx;
    logic             busy;
    logic             done;

    modport master (
        output ena, start, hold, msg_sel, mode, div,
        input  char_out, char_valid, char_idx, busy, done
    );

    modport slave (
        input  ena, start, hold, msg_sel, mode, div,
        output char_out, char_valid, char_idx, busy, done
    );
endinterface

// File: rtl/ascii_msg_sequencer.sv
// ascii_msg_sequencer: streams one of four fixed ASCII messages, one
// character per (div+1) cycles, in loop, one-shot, ping-pong or reverse
// order. Message and mode selects are only sampled at start and at pass
// boundaries so a pass is never torn between two messages.
module ascii_msg_sequencer #(
    parameter int DIV_W = 16,
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ascii_msg_sequencer_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_ONE  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_REV  = 2'b11;

    // First character sits in the most significant byte of each string.
    localparam logic [8*9-1:0]  MSG0 = "Guatemala";
    localparam logic [8*7-1:0]  MSG1 = "Quetzal";
    localparam logic [8*6-1:0]  MSG2 = "Zacapa";
    localparam logic [8*13-1:0] MSG3 = "Soy de Zacapa";

    function automatic logic [IDX_W-1:0] msg_len(input logic [1:0] sel);
        case (sel)
            2'd0:    msg_len = IDX_W'(9);
            2'd1:    msg_len = IDX_W'(7);
            2'd2:    msg_len = IDX_W'(6);
            default: msg_len = IDX_W'(13);
        endcase
    endfunction

    function automatic logic [7:0] rom_char(input logic [1:0] sel, input logic [IDX_W-1:0] idx);
        int p;
        p        = int'(idx);
        rom_char = 8'h00;
        case (sel)
            2'd0:    if (p < 9)  rom_char = MSG0[8*(8-p)  +: 8];
            2'd1:    if (p < 7)  rom_char = MSG1[8*(6-p)  +: 8];
            2'd2:    if (p < 6)  rom_char = MSG2[8*(5-p)  +: 8];
            default: if (p < 13) rom_char = MSG3[8*(12-p) +: 8];
        endcase
    endfunction

    logic [0:0]       r_state;
    logic [1:0]       r_sel;
    logic [1:0]       r_mode;
    logic [DIV_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_next;
    logic             r_down;
    logic [7:0]       r_char;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_done;

    logic             w_frozen;
    logic             w_tick;
    logic [IDX_W-1:0] w_start_in;
    logic [IDX_W-1:0] w_last;
    logic [IDX_W-1:0] w_next_adv;
    logic             w_down_adv;
    logic             w_boundary;
    logic             w_finish;

    assign w_frozen = !bus.ena || bus.hold;
    assign w_tick   = (r_cnt == bus.div);
    assign w_last   = msg_len(r_sel) - IDX_W'(1);

    // Start index for a pass, taken from the live selects (used at start and at the boundary).
    assign w_start_in = (bus.mode == MODE_REV) ? (msg_len(bus.msg_sel) - IDX_W'(1)) : '0;

    // Next-index sequencing for the currently latched mode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        w_next_adv = r_next;
        w_down_adv = r_down;
        w_boundary = 1'b0;
        w_finish   = 1'b0;
        case (r_mode)
            MODE_FWD: begin
                if (r_next == w_last) w_boundary = 1'b1;
                else                  w_next_adv = r_next + IDX_W'(1);
            end
            MODE_ONE: begin
                if (r_next == w_last) begin
                    w_finish   = 1'b1;
                    w_next_adv = '0;
                end else begin
                    w_next_adv = r_next + IDX_W'(1);
                end
            end
            MODE_PING: begin
                if (!r_down) begin
                    if (r_next == w_last) begin
                        w_down_adv = 1'b1;
                        w_next_adv = r_next - IDX_W'(1);
                    end else begin
                        w_next_adv = r_next + IDX_W'(1);
                    end
                end else if (r_next == IDX_W'(1)) begin
                    w_boundary = 1'b1;
                end else begin
                    w_next_adv = r_next - IDX_W'(1);
                end
            end
            default: begin
                if (r_next == '0) w_boundary = 1'b1;
                else              w_next_adv = r_next - IDX_W'(1);
            end
        endcase
        if (w_boundary) begin
            w_next_adv = w_start_in;
            w_down_adv = 1'b0;
        end
    end

    // Control FSM, prescaler and registered character outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_mode  <= MODE_FWD;
            r_cnt   <= '0;
            r_next  <= '0;
            r_down  <= 1'b0;
            r_char  <= 8'h00;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (!w_frozen) begin
                if (bus.start) begin
                    r_state <= ST_RUN;
                    r_sel   <= bus.msg_sel;
                    r_mode  <= bus.mode;
                    r_cnt   <= '0;
                    r_next  <= w_start_in;
                    r_down  <= 1'b0;
                end else if (r_state == ST_RUN) begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_char  <= rom_char(r_sel, r_next);
                        r_idx   <= r_next;
                        r_valid <= 1'b1;
                        r_next  <= w_next_adv;
                        r_down  <= w_down_adv;
                        if (w_boundary) begin
                            r_sel  <= bus.msg_sel;
                            r_mode <= bus.mode;
                        end
                        if (w_finish) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
            end
        end
    end

    assign bus.char_out   = r_char;
    assign bus.char_valid = r_valid;
    assign bus.char_idx   = r_idx;
    assign bus.busy       = (r_state == ST_RUN);
    assign bus.done       = r_done;

endmodule

// File: tb/tb_ascii_msg_sequencer.sv
// Self-checking bench for ascii_msg_sequencer: directed scenarios followed by
// randomized control traffic, every cycle compared against a pass-list model.
module tb_ascii_msg_sequencer;

    localparam int DIV_W = 16;
    localparam int IDX_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ascii_msg_sequencer_if #(.DIV_W(DIV_W), .IDX_W(IDX_W)) bus ();

    ascii_msg_sequencer #(.DIV_W(DIV_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    string msgs [4] = '{"Guatemala", "Quetzal", "Zacapa", "Soy de Zacapa"};

    // Reference model: each pass is an explicit list of indices to emit.
    bit          m_busy;
    int          m_sel;
    int          m_mode;
    int          m_pass [$];
    int          m_pos;
    int unsigned m_cnt;
    logic [7:0]  m_char;
    int          m_idx;
    bit          m_valid;
    bit          m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void build_pass(input int s, input int md);
        int len;
        len = msgs[s].len();
        m_pass.delete();
        case (md)
            3: for (int i = len - 1; i >= 0; i--) m_pass.push_back(i);
            2: begin
                for (int i = 0; i < len; i++)      m_pass.push_back(i);
                for (int i = len - 2; i >= 1; i--) m_pass.push_back(i);
            end
            default: for (int i = 0; i < len; i++) m_pass.push_back(i);
        endcase
    endfunction

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_sel   = 0;
        m_mode  = 0;
        m_pos   = 0;
        m_cnt   = 0;
        m_char  = 8'h00;
        m_idx   = 0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_pass.delete();
    endfunction

    function automatic void model_step();
        bit frozen;
        frozen  = !bus.ena || bus.hold;
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (!frozen) begin
            if (bus.start) begin
                m_busy = 1'b1;
                m_sel  = int'(bus.msg_sel);
                m_mode = int'(bus.mode);
                build_pass(m_sel, m_mode);
                m_pos  = 0;
                m_cnt  = 0;
            end else if (m_busy) begin
                if (m_cnt == int'(bus.div)) begin
                    m_cnt   = 0;
                    m_idx   = m_pass[m_pos];
                    m_char  = msgs[m_sel][m_idx];
                    m_valid = 1'b1;
                    m_pos++;
                    if (m_pos == m_pass.size()) begin
                        if (m_mode == 1) begin
                            m_done = 1'b1;
                            m_busy = 1'b0;
                        end else begin
                            m_sel  = int'(bus.msg_sel);
                            m_mode = int'(bus.mode);
                            build_pass(m_sel, m_mode);
                            m_pos  = 0;
                        end
                    end
                end else begin
                    m_cnt = (m_cnt + 1) % (1 << DIV_W);
                end
            end
        end
    endfunction

    // Advance the model on each edge (or async reset) and compare 1 time unit later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("char_valid", 32'(bus.char_valid), 32'(m_valid));
        check("done",       32'(bus.done),       32'(m_done));
        check("busy",       32'(bus.busy),       32'(m_busy));
        check("char_out",   32'(bus.char_out),   32'(m_char));
        check("char_idx",   32'(bus.char_idx),   32'(m_idx));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input int s, input int md, input int dv);
        bus.start   = 1'b1;
        bus.msg_sel = 2'(s);
        bus.mode    = 2'(md);
        bus.div     = DIV_W'(dv);
        cycles(1);
        bus.start   = 1'b0;
    endtask

    initial begin
        bus.ena     = 1'b1;
        bus.start   = 1'b0;
        bus.hold    = 1'b0;
        bus.msg_sel = 2'd0;
        bus.mode    = 2'd0;
        bus.div     = '0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);

        // Loop-forward, strobe every cycle, wraps back to 'G'.
        go(0, 0, 0);
        cycles(12);

        // One-shot with div=3; ends idle holding 0x6C.
        go(1, 1, 3);
        cycles(34);
        check("oneshot_last_char", 32'(bus.char_out), 32'h6C);
        check("oneshot_idle",      32'(bus.busy),     32'h0);

        // Ping-pong on "Zacapa".
        go(2, 2, 0);
        cycles(14);

        // Loop-reverse; message select changed mid-pass.
        go(3, 3, 0);
        cycles(8);
        bus.msg_sel = 2'd0;
        cycles(16);

        // Hold for 5 cycles with a start attempt inside the hold.
        go(0, 0, 2);
        cycles(7);
        bus.hold  = 1'b1;
        cycles(2);
        bus.start = 1'b1;
        cycles(1);
        bus.start = 1'b0;
        cycles(2);
        bus.hold  = 1'b0;
        cycles(12);

        // Restart coincident with a tick (div=0 ticks every cycle).
        go(1, 0, 0);
        cycles(5);
        go(1, 0, 0);
        cycles(4);

        // Asynchronous reset mid-pass, then stays idle without a start.
        go(3, 0, 1);
        cycles(9);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(6);
        check("idle_after_reset", 32'(bus.busy), 32'h0);

        // Randomized control traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.start = 1'b0;
            if (r < 3) begin
                bus.ena     = 1'b1;
                bus.hold    = 1'b0;
                bus.start   = 1'b1;
                bus.msg_sel = 2'($urandom);
                bus.mode    = 2'($urandom);
                bus.div     = DIV_W'($urandom_range(0, 4));
            end else begin
                bus.ena  = ($urandom_range(0, 9) != 0);
                bus.hold = ($urandom_range(0, 14) == 0);
                if ($urandom_range(0, 19) == 0) bus.msg_sel = 2'($urandom);
                if ($urandom_range(0, 19) == 0) bus.mode    = 2'($urandom);
                if ($urandom_range(0, 39) == 0) bus.start   = 1'b1;
            end
            cycles(1);
        end

        bus.ena   = 1'b1;
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
